serial_subtractor: RTL and testbench
====================================

// Module: serial_subtractor
// PURPOSE
//   Bit-serial unsigned subtractor: the inverse operation of the team's combinational adder.
//   Accepts operands a, b on a valid/ready handshake and resolves one bit per cycle, LSB first.
//   Returns diff = (a - b) mod 2^WIDTH and borrow = (a < b) on a second valid/ready handshake.
//   Used where a ripple subtract is too wide for timing and multi-cycle latency is acceptable.
// PARAMETERS
//   WIDTH   4   operand/result width in bits (>= 2)
// PORTS
//   clk        in   1      single clock, rising edge
//   rst        in   1      asynchronous, active-high reset
//   in_valid   in   1      a/b presented
//   in_ready   out  1      block can accept operands (high only in IDLE)
//   a          in   WIDTH  minuend, unsigned, sampled only on input handshake
//   b          in   WIDTH  subtrahend, unsigned, sampled only on input handshake
//   out_valid  out  1      diff/borrow hold a completed result (high only in DONE)
//   out_ready  in   1      consumer takes the result
//   diff       out  WIDTH  (a - b) mod 2^WIDTH
//   borrow     out  1      1 iff a < b (unsigned)
// BEHAVIOUR
//   - Reset (async, any state): state=IDLE, count=0, borrow-chain=0, diff=0, borrow=0,
//     out_valid=0; in_ready=1 while rst is high and after release. Any in-flight op is aborted; no result.
//   - in_ready = (state==IDLE); out_valid = (state==DONE); both decoded from registered state.
//   - IDLE: on in_valid & in_ready at edge k: latch a->ra, b->rb, br=0, count=0, go BUSY.
//   - BUSY (exactly WIDTH cycles): each edge, with x=ra[0], y=rb[0]:
//       d = x ^ y ^ br;  br_next = (~x & y) | (~(x ^ y) & br);
//       ra, rb shift right by 1; d shifts into MSB of shift register sr; count++.
//     On the edge where count==WIDTH-1: diff <= final sr contents, borrow <= br_next, go DONE.
//   - Latency: input handshake at edge k -> out_valid high after edge k+WIDTH (WIDTH cycles).
//   - DONE: diff/borrow stable, out_valid=1 until out_valid & out_ready; then go IDLE.
//     No same-cycle re-accept: next operands taken no earlier than the cycle after leaving DONE.
//   - in_valid in BUSY/DONE is ignored; a/b may change freely outside the handshake cycle.
//   - out_ready outside DONE is ignored; out_ready held high -> DONE lasts exactly 1 cycle.
//   - diff/borrow registers only update on BUSY->DONE; they hold the last result in IDLE/BUSY
//     and are meaningful only while out_valid=1.
//   - Throughput: one op per WIDTH+2 cycles with out_ready held high.
//   - Wrap-around: a<b yields two's-complement wrap in diff, borrow=1; a==b -> diff=0, borrow=0.
//   - State encoding: IDLE, BUSY, DONE; illegal encodings return to IDLE on next edge.
// TESTING
//   1. a=9,b=3 (WIDTH=4), out_ready=1 -> out_valid exactly 4 cycles after accept, diff=6, borrow=0.
//   2. a=3,b=9 -> diff=10 (4'hA), borrow=1; a=0,b=15 -> diff=1, borrow=1; a=7,b=7 -> diff=0, borrow=0.
//   3. Exhaustive a,b in 0..15 -> diff==(a-b)&15, borrow==(a<b), and (diff+b)&15==a; any mismatch prints ERROR.
//   4. Backpressure: hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with new a/b ->
//      diff/borrow/out_valid stable, in_ready=0, new operands not taken; release -> IDLE next cycle.
//   5. Assert rst 2 cycles into BUSY (a=12,b=5) -> immediately out_valid=0, in_ready=1, diff=0;
//      after release a=12,b=5 -> diff=7, borrow=0 with normal 4-cycle latency.
//   6. Back-to-back: in_valid and out_ready held high, 3 ops -> accepts spaced 6 cycles, results in order.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = (a - b) mod 2^WIDTH, borrow = (a < b).
// One bit is resolved per cycle, LSB first, between an input and an output valid/ready handshake.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic [1:0]       dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both
  // high. in_ready/out_valid are decoded from registered state only, and each side
  // may change its valid freely when the other side is not ready.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic [WIDTH-1:0] sr;
  logic [CW-1:0]    count;
  logic             br;

  logic             x;
  logic             y;
  logic             d;
  logic             br_next;
  logic [WIDTH-1:0] sr_next;

  // Full-subtractor cell applied to the current LSBs of the operand shifters.
  assign x       = ra[0];
  assign y       = rb[0];
  assign d       = x ^ y ^ br;
  assign br_next = (~x & y) | (~(x ^ y) & br);
  assign sr_next = {d, sr[WIDTH-1:1]};

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign dbg_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      ra     <= '0;
      rb     <= '0;
      sr     <= '0;
      count  <= '0;
      br     <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            ra    <= a;
            rb    <= b;
            sr    <= '0;
            br    <= 1'b0;
            count <= '0;
            state <= BUSY;
          end
        end
        BUSY: begin
          ra    <= ra >> 1;
          rb    <= rb >> 1;
          br    <= br_next;
          sr    <= sr_next;
          count <= count + 1'b1;
          // The last bit lands in sr_next this cycle, so publish from the next-value path.
          if (count == LAST) begin
            diff   <= sr_next;
            borrow <= br_next;
            state  <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed, exhaustive, backpressure,
// mid-operation reset and back-to-back throughput, with an expected-result queue.
module tb_serial_subtractor;
  localparam int W = 4;
  localparam logic [W-1:0] MASK = '1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] diff;
  logic         borrow;
  logic [1:0]   dbg_state;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .borrow    (borrow),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int errors = 0;
  int checks = 0;

  // entry = {a, b, borrow, diff}
  logic [3*W:0] exp_q[$];
  int           acc_q[$];
  int           last_acc = -1;
  bit           chk_gap  = 1'b0;
  bit           prev_ov  = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Present operands and hold in_valid until accepted; in_valid stays high afterwards.
  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y);
    int n;
    logic [W-1:0] ed;
    n = 0;
    @(posedge clk); #1;
    in_valid = 1'b1;
    a = x;
    b = y;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 100) begin
        check("accept_timeout", 0, 1);
        in_valid = 1'b0;
        return;
      end
    end
    ed = x - y;
    exp_q.push_back({x, y, (x < y), ed});
    acc_q.push_back(cyc);
    if (chk_gap && last_acc >= 0) check("b2b_gap", cyc - last_acc, W + 2);
    last_acc = cyc;
  endtask

  task automatic drop_valid();
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0) begin
      @(negedge clk);
      n++;
      if (n > 200) begin
        check("drain_timeout", exp_q.size(), 0);
        exp_q.delete();
        acc_q.delete();
      end
    end
  endtask

  // Output monitor: latency on out_valid rise, result compare on the output handshake.
  always @(negedge clk) begin
    logic [3*W:0] e;
    if (!rst) begin
      if (out_valid && !prev_ov && acc_q.size() != 0)
        check("latency", cyc - acc_q[0], W + 1);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          e = exp_q.pop_front();
          if (acc_q.size() != 0) void'(acc_q.pop_front());
          check("diff", diff, e[W-1:0]);
          check("borrow", borrow, e[W]);
          check("add_back", (diff + e[2*W:W+1]) & MASK, e[3*W:2*W+1]);
        end
      end
    end
    prev_ov = out_valid;
  end

  initial begin
    logic [W-1:0] r;
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_diff", diff, 0);
    check("rst_borrow", borrow, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;

    // Directed values
    send(4'd9, 4'd3);  drop_valid(); drain();
    send(4'd3, 4'd9);  drop_valid(); drain();
    send(4'd0, 4'd15); drop_valid(); drain();
    send(4'd7, 4'd7);  drop_valid(); drain();

    // Exhaustive
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++) begin
        send(W'(i), W'(j));
        drop_valid();
      end
    drain();

    // Backpressure in DONE with competing operands on the input
    out_ready = 1'b0;
    send(4'd9, 4'd4);
    drop_valid();
    for (int n = 0; n < 50 && !out_valid; n++) @(negedge clk);
    check("bp_reach_done", out_valid, 1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      r = W'($urandom_range(0, 15));
      a = r;
      b = ~r;
      @(negedge clk);
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_diff", diff, 4'd5);
      check("bp_borrow", borrow, 0);
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_idle_after", in_ready, 1);
    check("bp_no_extra", exp_q.size(), 0);

    // Reset two cycles into BUSY
    send(4'd12, 4'd5);
    drop_valid();
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_diff", diff, 0);
    check("mid_rst_state", dbg_state, 0);
    exp_q.delete();
    acc_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    send(4'd12, 4'd5); drop_valid(); drain();

    // Back-to-back throughput
    last_acc = -1;
    chk_gap  = 1'b1;
    send(4'd1, 4'd2);
    send(4'd15, 4'd0);
    send(4'd8, 4'd8);
    drop_valid();
    drain();
    chk_gap = 1'b0;

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "timeout");
  end
endmodule
